// File: rtl/tiny_dnn_pkg.sv
// Shared types and sizes for the tiny_dnn neuron: core, sequencer and layer controller.
package tiny_dnn_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned F_SIZE = 1024;
  localparam int unsigned PIPE   = 2;

  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(F_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_EXEC,
    S_BIAS,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq_if.sv
// Sequencer bus: host request/result side plus the core control side.
interface tiny_dnn_seq_if;
  import tiny_dnn_pkg::*;

  logic              start;
  logic              load;
  logic [ADDR_W-1:0] f_num;
  logic              wvalid;
  real               win;
  logic              busy;
  logic              out_valid;
  real               y;
  logic [ADDR_W-1:0] da;
  logic              init;
  logic              exec;
  logic              bias;
  logic              write;
  logic              bwrite;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] wa;
  real               wd;
  real               sum;

  // master: host + core environment; slave: the sequencer
  modport master (
    output start, load, f_num, wvalid, win, sum,
    input  busy, out_valid, y, da, init, exec, bias, write, bwrite, ra, wa, wd
  );

  modport slave (
    input  start, load, f_num, wvalid, win, sum,
    output busy, out_valid, y, da, init, exec, bias, write, bwrite, ra, wa, wd
  );

endinterface

// File: rtl/tiny_dnn_addr_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count flag (cnt == limit).
module tiny_dnn_addr_cnt
  import tiny_dnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic              en,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/tiny_dnn_seq.sv
// Dot-product sequencer for one tiny_dnn_core: weight load, clear/MAC/bias, pipeline drain.
// Optional bias slot and BIAS state enabled by defining TINY_DNN_SEQ_BIAS_EN.
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
(
  input logic           clk,
  input logic           reset,
  tiny_dnn_seq_if.slave bus
);

  localparam int unsigned DRAIN_W = $clog2(PIPE + 1);

  seq_state_t         state;
  logic [ADDR_W-1:0]  n_lat;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ADDR_W-1:0]  rd_cnt, wr_cnt, wr_limit;
  logic               rd_tc, wr_tc;
  logic               rd_clr, rd_en, wr_clr, wr_en;
  logic               load_empty;

  // Counters hold the next address to issue; the registered ra/da/wa trail them by one.
`ifdef TINY_DNN_SEQ_BIAS_EN
  assign wr_limit   = n_lat;
  assign load_empty = 1'b0;
`else
  assign wr_limit   = n_lat - ADDR_W'(1);
  assign load_empty = (n_lat == '0);
`endif

  always_comb begin
    rd_clr = 1'b0;
    rd_en  = 1'b0;
    wr_clr = 1'b0;
    wr_en  = 1'b0;
    case (state)
      S_IDLE: begin
        rd_clr = bus.start;
        wr_clr = bus.load & ~bus.start;
      end
      S_LOAD:         wr_en = bus.wvalid & ~wr_tc;
      S_INIT, S_EXEC: rd_en = ~rd_tc;
      default: ;
    endcase
  end

  tiny_dnn_addr_cnt u_rd_cnt (
    .clk(clk), .reset(reset), .clr(rd_clr), .ld(1'b0), .en(rd_en),
    .ld_val('0), .limit(n_lat), .cnt(rd_cnt), .tc(rd_tc)
  );

  tiny_dnn_addr_cnt u_wr_cnt (
    .clk(clk), .reset(reset), .clr(wr_clr), .ld(1'b0), .en(wr_en),
    .ld_val('0), .limit(wr_limit), .cnt(wr_cnt), .tc(wr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      n_lat         <= '0;
      drain_cnt     <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.init      <= 1'b0;
      bus.exec      <= 1'b0;
      bus.bias      <= 1'b0;
      bus.write     <= 1'b0;
      bus.bwrite    <= 1'b0;
      bus.ra        <= '0;
      bus.wa        <= '0;
      bus.da        <= '0;
      bus.y         <= 0.0;
      bus.wd        <= 0.0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.init      <= 1'b0;
      bus.exec      <= 1'b0;
      bus.bias      <= 1'b0;
      bus.write     <= 1'b0;
      bus.bwrite    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_lat    <= bus.f_num;
            state    <= S_INIT;
            bus.init <= 1'b1;
            bus.busy <= 1'b1;
          end else if (bus.load) begin
            n_lat    <= bus.f_num;
            state    <= S_LOAD;
            bus.busy <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_empty) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else if (bus.wvalid) begin
            bus.write <= 1'b1;
            bus.wd    <= bus.win;
            bus.wa    <= wr_cnt;
            if (wr_tc) begin
`ifdef TINY_DNN_SEQ_BIAS_EN
              bus.wa     <= BIAS_ADDR;
              bus.bwrite <= 1'b1;
`endif
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        // INIT shares the EXEC issue logic so N=0 falls straight through
        S_INIT, S_EXEC: begin
          if (rd_tc) begin
`ifdef TINY_DNN_SEQ_BIAS_EN
            state    <= S_BIAS;
            bus.bias <= 1'b1;
            bus.ra   <= BIAS_ADDR;
`else
            state     <= S_DRAIN;
            drain_cnt <= '0;
`endif
          end else begin
            state    <= S_EXEC;
            bus.exec <= 1'b1;
            bus.ra   <= rd_cnt;
            bus.da   <= rd_cnt;
          end
        end
        S_BIAS: begin
          state     <= S_DRAIN;
          drain_cnt <= '0;
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_W'(PIPE - 1)) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        S_DONE: begin
          bus.y         <= bus.sum;
          bus.out_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Self-checking bench for tiny_dnn_seq with a behavioural 2-stage core and input buffer.
module tb_tiny_dnn_seq;
  import tiny_dnn_pkg::*;

`ifdef TINY_DNN_SEQ_BIAS_EN
  localparam int BIAS_EN = 1;
`else
  localparam int BIAS_EN = 0;
`endif

  bit clk = 1'b0;
  bit reset;
  always #5 clk = ~clk;

  tiny_dnn_seq_if bus ();

  tiny_dnn_seq dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  real wmem [F_SIZE];
  real dmem [F_SIZE];
  real wv [16];
  real bv;

  int  wq_a [$];
  real wq_d [$];
  bit  wq_b [$];
  int  n_exec = 0, n_init = 0, n_overlap = 0, n_ov = 0;

  bit  p_init = 1'b0;
  real p_term = 0.0;

  // Weight RAM, event counters and a core whose sum updates 2 cycles after issue
  always @(posedge clk) begin
    if (bus.write === 1'b1) begin
      wq_a.push_back(int'(bus.wa));
      wq_d.push_back(bus.wd);
      wq_b.push_back(bus.bwrite);
      wmem[bus.wa] = bus.wd;
    end
    if (bus.exec === 1'b1) n_exec++;
    if (bus.init === 1'b1) n_init++;
    if (bus.init === 1'b1 && bus.exec === 1'b1) n_overlap++;
    if (bus.out_valid === 1'b1) n_ov++;
    bus.sum <= p_init ? 0.0 : bus.sum + p_term;
    p_init  <= (bus.init === 1'b1);
    p_term  <= (bus.exec === 1'b1) ? wmem[bus.ra] * dmem[bus.da] :
               (bus.bias === 1'b1) ? wmem[F_SIZE-1] : 0.0;
  end

  task automatic chk_int(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real got, input real exp);
    tests++;
    assert (got == exp) else begin
      fails++;
      $error("FAIL %s: got %f expected %f", tag, got, exp);
    end
  endtask

  function automatic real rnd_val();
    return real'(int'($urandom_range(0, 16))) * 0.25 - 2.0;
  endfunction

  // Reference: plain dot product of the stimulus plus the bias when enabled
  function automatic real ref_dot(input int n);
    real s = 0.0;
    for (int i = 0; i < n; i++) s += wv[i] * dmem[i];
    s += real'(BIAS_EN) * bv;
    return s;
  endfunction

  task automatic chk_zero(input string tag);
    chk_int({tag, "_ctl"}, {bus.busy, bus.out_valid, bus.init, bus.exec,
                            bus.bias, bus.write, bus.bwrite}, 0);
    chk_int({tag, "_addr"}, {bus.ra, bus.wa, bus.da}, 0);
    chk_real({tag, "_y"}, bus.y, 0.0);
    chk_real({tag, "_wd"}, bus.wd, 0.0);
  endtask

  task automatic do_load(input int n, input bit gappy);
    int nw, w0;
    nw = n + BIAS_EN;
    if (nw == 0) return;
    w0 = wq_a.size();
    @(posedge clk); #1;
    bus.load = 1'b1;
    bus.f_num = 10'(n);
    @(posedge clk); #1;
    bus.load = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (gappy) begin
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.wvalid = 1'b1;
      bus.win = (i == n) ? bv : wv[i];
      @(negedge clk);
      chk_int("busy_load", bus.busy, 1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    @(negedge clk);
    chk_int("load_end_busy", bus.busy, 0);
    chk_int("load_last_write", bus.write, 1);
    repeat (2) @(posedge clk);
    #1;
    chk_int("wr_count", wq_a.size() - w0, nw);
    for (int i = 0; i < nw; i++) begin
      chk_int("wr_addr", wq_a[w0+i], (i == n) ? F_SIZE - 1 : i);
      chk_real("wr_data", wq_d[w0+i], (i == n) ? bv : wv[i]);
      chk_int("wr_bwrite", wq_b[w0+i], (i == n) ? 1 : 0);
    end
  endtask

  task automatic do_run(input int n, input bit with_load, input int poke);
    int k, e0, i0, w0, o0, v0;
    bit seen;
    real exp_y;
    exp_y = ref_dot(n);
    e0 = n_exec; i0 = n_init; w0 = wq_a.size(); o0 = n_overlap; v0 = n_ov;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.load = with_load;
    bus.f_num = 10'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.load = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (k == poke) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k++;
      end
    end
    chk_int("ov_seen", seen, 1);
    chk_int("ov_cycle", k, n + 5 + BIAS_EN);
    chk_real("y", bus.y, exp_y);
    chk_int("busy_at_ov", bus.busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_int("busy_after", bus.busy, 0);
    chk_int("exec_pulses", n_exec - e0, n);
    chk_int("init_pulses", n_init - i0, 1);
    chk_int("init_exec_overlap", n_overlap - o0, 0);
    chk_int("ov_pulses", n_ov - v0, 1);
    chk_int("run_writes", wq_a.size() - w0, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.load = 1'b0;
    bus.f_num = '0;
    bus.wvalid = 1'b0;
    bus.win = 0.0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic load and run, N=3
    wv[0] = 1.0; wv[1] = 2.0; wv[2] = 3.0; bv = 0.5;
    for (int i = 0; i < 3; i++) dmem[i] = 1.0;
    do_load(3, 1'b0);
    do_run(3, 1'b0, 0);

    // Gappy load, N=2
    wv[0] = rnd_val(); wv[1] = rnd_val(); bv = rnd_val();
    dmem[0] = rnd_val(); dmem[1] = rnd_val();
    do_load(2, 1'b1);
    do_run(2, 1'b0, 0);

    // N=0: bias only
    bv = 0.25;
    do_load(0, 1'b0);
    do_run(0, 1'b0, 0);

    // Reset in the third EXEC cycle of an N=8 run
    for (int i = 0; i < 8; i++) begin
      wv[i] = rnd_val();
      dmem[i] = rnd_val();
    end
    bv = rnd_val();
    do_load(8, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.f_num = 10'(8);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("exec_before_reset", bus.exec, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");

    wv[0] = 1.0; wv[1] = 1.0; bv = 0.0;
    dmem[0] = 2.0; dmem[1] = 2.0;
    do_load(2, 1'b0);
    do_run(2, 1'b0, 0);

    // start+load together, then start poked during EXEC
    do_run(2, 1'b1, 0);
    do_run(2, 1'b0, 3);

    // Randomized load/run pairs
    for (int it = 0; it < 8; it++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        wv[i] = rnd_val();
        dmem[i] = rnd_val();
      end
      bv = rnd_val();
      do_load(n, 1'($urandom_range(0, 1)));
      do_run(n, 1'b0, (n >= 2) ? int'($urandom_range(0, 3)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
